// File: rtl/gpr_wb_ctrl.sv
// GPR write-back controller: merges single-cycle ALU results with in-order load
// responses onto one registered write port and keeps a scoreboard of pending load targets.
module gpr_wb_ctrl #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_wb_valid,
  input  logic [ADDR_W-1:0] alu_wb_addr,
  input  logic [DATA_W-1:0] alu_wb_data,
  input  logic              ld_issue_valid,
  input  logic [ADDR_W-1:0] ld_issue_addr,
  output logic              ld_issue_ready,
  input  logic              ld_rsp_valid,
  input  logic [DATA_W-1:0] ld_rsp_data,
  output logic              ld_rsp_ready,
  input  logic [ADDR_W-1:0] chk_addr_0,
  input  logic [ADDR_W-1:0] chk_addr_1,
  output logic              busy_0,
  output logic              busy_1,
  output logic              we_,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              ld_err
);

  localparam int unsigned PW       = $clog2(LQ_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(LQ_DEPTH);

  logic [ADDR_W-1:0]   lq_q [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]       wp_q, rp_q;
  logic [PW:0]         cnt_q, cnt_d;
  logic                we_q, err_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                full, empty, push, rsp_acc, pop;
  logic                b0, b1;
  logic [ADDR_W-1:0]   head;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign push    = ld_issue_valid && !full;
  assign rsp_acc = ld_rsp_valid && !alu_wb_valid;
  // Emptiness is judged on the registered count, so a same-cycle push cannot absorb a response.
  assign pop     = rsp_acc && !empty;
  assign head    = lq_q[rp_q];

  assign ld_issue_ready = !full;
  assign ld_rsp_ready   = !alu_wb_valid;
  assign we_            = we_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;
  assign ld_err         = err_q;
  assign busy_0         = b0;
  assign busy_1         = b1;

  always_comb begin
    vld_d = vld_q;
    if (pop)  vld_d[rp_q] = 1'b0;
    if (push) vld_d[wp_q] = 1'b1;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    b0 = 1'b0;
    b1 = 1'b0;
    for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
      if (vld_q[i] && lq_q[i] == chk_addr_0) b0 = 1'b1;
      if (vld_q[i] && lq_q[i] == chk_addr_1) b1 = 1'b1;
    end
    if (chk_addr_0 == '0) b0 = 1'b0;
    if (chk_addr_1 == '0) b1 = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LQ_DEPTH; i++) lq_q[i] <= '0;
      vld_q     <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b1;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (push) begin
        lq_q[wp_q] <= ld_issue_addr;
        wp_q       <= wp_q + PW'(1);
      end
      if (pop) rp_q <= rp_q + PW'(1);
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      if (rsp_acc && empty) err_q <= 1'b1;

      // Address and data only move on a real write; suppressed x0 writes leave them held.
      we_q <= 1'b1;
      if (alu_wb_valid) begin
        if (alu_wb_addr != '0) begin
          we_q      <= 1'b0;
          wr_addr_q <= alu_wb_addr;
          wr_data_q <= alu_wb_data;
        end
      end else if (pop) begin
        if (head != '0) begin
          we_q      <= 1'b0;
          wr_addr_q <= head;
          wr_data_q <= ld_rsp_data;
        end
      end
    end
  end

endmodule
